// File: rtl/seq_detect_sched.sv
// seq_detect_sched: round-robin scheduler sharing one bit-serial Moore
// pattern detector among NREQ requesters; reports overlapping hit counts.
`timescale 1ns/1ps
`default_nettype none

module seq_detect_sched #(
  parameter int          NREQ    = 4,
  parameter int          WORD_W  = 8,
  parameter int          CNT_W   = 4,
  parameter logic [3:0]  PATTERN = 4'b1011
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WORD_W-1:0]     data,
  output logic [NREQ-1:0]            grant,
  output logic                       busy,
  output logic                       ser_bit,
  output logic                       ser_valid,
  output logic                       done,
  output logic [$clog2(NREQ)-1:0]    done_id,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int ID_W = $clog2(NREQ);
  localparam int BC_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [2:0]         hist_q, hist_d;
  logic [BC_W-1:0]    bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]   hits_q, hits_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

  logic               req_found;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    scan_idx;
  logic               shift_bit;
  logic               hit;

  // Round-robin scan: start just after the last-served requester, wrap modulo NREQ.
  always_comb begin
    req_found = 1'b0;
    winner    = last_q;
    scan_idx  = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = last_q + ID_W'(k);
      if (!req_found && req[scan_idx]) begin
        req_found = 1'b1;
        winner    = scan_idx;
      end
    end
  end

  assign shift_bit = shreg_q[WORD_W-1];
  // Moore-style hit: full 4-bit window present, counted on its last bit.
  assign hit = ({hist_q, shift_bit} == PATTERN) && (bitcnt_q >= BC_W'(3));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    shreg_d     = shreg_q;
    hist_d      = hist_q;
    bitcnt_d    = bitcnt_q;
    hits_d      = hits_q;
    last_d      = last_q;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          state_d  = SHIFT;
          grant_d  = NREQ'(1) << winner;
          shreg_d  = data[int'(winner)*WORD_W +: WORD_W];
          last_d   = winner;
          hist_d   = 3'b000;
          bitcnt_d = '0;
          hits_d   = '0;
        end
      end
      SHIFT: begin
        shreg_d  = {shreg_q[WORD_W-2:0], 1'b0};
        hist_d   = {hist_q[1:0], shift_bit};
        bitcnt_d = bitcnt_q + BC_W'(1);
        hits_d   = hits_q + CNT_W'(hit);
        if (bitcnt_q == BC_W'(WORD_W-1)) begin
          state_d     = REPORT;
          match_cnt_d = hits_q + CNT_W'(hit);
          done_id_d   = last_q;
        end
      end
      REPORT: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      shreg_q     <= '0;
      hist_q      <= 3'b000;
      bitcnt_q    <= '0;
      hits_q      <= '0;
      last_q      <= ID_W'(NREQ-1);
      done_id_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      shreg_q     <= shreg_d;
      hist_q      <= hist_d;
      bitcnt_q    <= bitcnt_d;
      hits_q      <= hits_d;
      last_q      <= last_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign ser_valid = (state_q == SHIFT);
  assign ser_bit   = ser_valid & shift_bit;
  assign done      = (state_q == REPORT);
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_sched.sv
// Self-checking bench for seq_detect_sched: directed scenarios plus random
// traffic compared against a transaction-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_seq_detect_sched;

  localparam int         NREQ    = 4;
  localparam int         WORD_W  = 8;
  localparam int         CNT_W   = 4;
  localparam logic [3:0] PATTERN = 4'b1011;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*WORD_W-1:0] data;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic                   ser_bit;
  logic                   ser_valid;
  logic                   done;
  logic [1:0]             done_id;
  logic [CNT_W-1:0]       match_cnt;

  int errors = 0;
  int checks = 0;
  int model_last;

  seq_detect_sched #(
    .NREQ   (NREQ),
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W),
    .PATTERN(PATTERN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data     (data),
    .grant    (grant),
    .busy     (busy),
    .ser_bit  (ser_bit),
    .ser_valid(ser_valid),
    .done     (done),
    .done_id  (done_id),
    .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // First set request after the last-served one, wrapping; -1 when none.
  function automatic int rr_pick(input int last, input logic [NREQ-1:0] rv);
    for (int k = 1; k <= NREQ; k++) begin
      if (rv[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Count every 4-bit window (MSB-first) that equals the pattern.
  function automatic int count_hits(input logic [WORD_W-1:0] w);
    int n = 0;
    for (int s = 0; s <= WORD_W - 4; s++) begin
      if (4'((w >> (WORD_W - 4 - s)) & 8'h0F) == PATTERN) n++;
    end
    return n;
  endfunction

  // Called #1 after a posedge with the DUT idle. drop_cyc selects the SHIFT
  // cycle (1-based) in which the winner drops req; scramble perturbs data.
  task automatic run_one(input logic [NREQ-1:0] rv, input logic [NREQ*WORD_W-1:0] dv,
                         input int drop_cyc, input bit scramble);
    int win;
    int exp_hits;
    logic [WORD_W-1:0] w;
    logic [NREQ-1:0] oh;
    req  = rv;
    data = dv;
    win  = rr_pick(model_last, rv);
    if (win < 0) begin
      @(posedge clk); #1;
      check_eq("idle_grant", grant, 0);
      check_eq("idle_busy", busy, 0);
      return;
    end
    w        = dv[win*WORD_W +: WORD_W];
    exp_hits = count_hits(w);
    oh       = NREQ'(1) << win;
    @(posedge clk); #1;
    check_eq("grant", grant, oh);
    model_last = win;
    for (int b = 0; b < WORD_W; b++) begin
      if (b > 0) begin
        @(posedge clk); #1;
      end
      check_eq("ser_valid", ser_valid, 1);
      check_eq("ser_bit", ser_bit, w[WORD_W-1-b]);
      check_eq("busy_shift", busy, 1);
      check_eq("done_early", done, 0);
      check_eq("grant_hold", grant, oh);
      if (b + 1 == drop_cyc) req[win] = 1'b0;
      if (scramble) data = {$urandom};
    end
    @(posedge clk); #1;
    check_eq("done", done, 1);
    check_eq("done_id", done_id, win);
    check_eq("match_cnt", match_cnt, exp_hits);
    check_eq("grant_report", grant, oh);
    check_eq("busy_report", busy, 1);
    check_eq("ser_valid_report", ser_valid, 0);
    req[win] = 1'b0;
    @(posedge clk); #1;
    check_eq("done_pulse", done, 0);
    check_eq("grant_idle", grant, 0);
    check_eq("busy_idle", busy, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    data       = '0;
    model_last = NREQ - 1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ser_bit", ser_bit, 0);
    check_eq("rst_ser_valid", ser_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_done_id", done_id, 0);
    check_eq("rst_match_cnt", match_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic single transaction
    run_one(4'b0001, 32'h0000_00B0, 0, 0);

    // Overlap and degenerate words on requester 2
    run_one(4'b0100, {8'h00, 8'b1011_0110, 16'h0000}, 0, 0);
    run_one(4'b0100, {8'h00, 8'hFF, 16'h0000}, 0, 0);
    run_one(4'b0100, {8'h00, 8'h00, 16'h0000}, 0, 0);

    // All four requesting; each releases on its own done
    model_last = 2;
    run_one(4'b1111, 32'hB0B6_5BFF, 0, 0);
    for (int i = 0; i < 3; i++) run_one(req, 32'hB0B6_5BFF, 0, 0);
    run_one(4'b0001, 32'h0000_00BB, 0, 0);

    // History must not carry across words
    run_one(4'b0010, {16'h0000, 8'b0000_0101, 8'h00}, 0, 0);
    run_one(4'b0010, {16'h0000, 8'b1000_0000, 8'h00}, 0, 0);

    // Reset in the 5th SHIFT cycle of a requester-2 transaction
    req  = 4'b0100;
    data = 32'h00B5_0000;
    @(posedge clk); #1;
    check_eq("pre_rst_grant", grant, 4'b0100);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_grant", grant, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_ser_valid", ser_valid, 0);
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    model_last = NREQ - 1;
    for (int i = 0; i < WORD_W + 2; i++) begin
      @(posedge clk); #1;
      check_eq("no_done_after_rst", done, 0);
    end
    run_one(4'b1010, 32'h0B00_00B0, 0, 0);

    // Requester 3 drops req in the 2nd SHIFT cycle
    run_one(4'b1000, {8'b0101_1011, 24'h0}, 2, 0);

    // Random traffic
    for (int it = 0; it < 60; it++) begin
      run_one(NREQ'($urandom_range(0, 15)), {$urandom},
              int'($urandom_range(0, WORD_W + 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
